// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU parameters for the CDB arbiter, with shift-based field extraction
// helpers that pull one FU's field out of a flattened bus.
package cdb_arbiter_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int RB_INDEX   = 4;
  localparam int RB_SIZE    = 1 << RB_INDEX;
  localparam int FU_NUM     = 6;
  localparam int STORER_NUM = 2;
  localparam int CDB_PORTS  = 2;

  localparam int FU_W       = $clog2(FU_NUM);
  localparam int STORE_BASE = FU_NUM - STORER_NUM;

  // All-ones index means "no destination"; such requests are never granted.
  localparam logic [RB_INDEX-1:0] NULL = '1;

  typedef logic [FU_W-1:0]      fu_id_t;
  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [RB_INDEX-1:0]  rb_idx_t;

  typedef struct packed {
    logic    valid;
    word_t   data;
    word_t   addr;
    rb_idx_t index;
  } cdb_slot_t;

  function automatic word_t get_data(input logic [FU_NUM*WORD_SIZE-1:0] bus, input int n);
    logic [FU_NUM*WORD_SIZE-1:0] sh;
    sh = bus >> (n * WORD_SIZE);
    return sh[WORD_SIZE-1:0];
  endfunction

  function automatic word_t get_addr(input logic [STORER_NUM*WORD_SIZE-1:0] bus, input int n);
    logic [STORER_NUM*WORD_SIZE-1:0] sh;
    sh = bus >> (n * WORD_SIZE);
    return sh[WORD_SIZE-1:0];
  endfunction

  function automatic rb_idx_t get_index(input logic [FU_NUM*RB_INDEX-1:0] bus, input int n);
    logic [FU_NUM*RB_INDEX-1:0] sh;
    sh = bus >> (n * RB_INDEX);
    return sh[RB_INDEX-1:0];
  endfunction

  function automatic fu_id_t next_fu(input fu_id_t f);
    return (int'(f) == FU_NUM - 1) ? '0 : f + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result / CDB bus bundle. The FU side is the master, the arbiter the slave.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [FU_NUM-1:0]               req;
  logic [FU_NUM*WORD_SIZE-1:0]     data_bus;
  logic [STORER_NUM*WORD_SIZE-1:0] addr_bus;
  logic [FU_NUM*RB_INDEX-1:0]      RB_index_bus;

  logic [FU_NUM-1:0]               grant;
  logic [CDB_PORTS-1:0]            cdb_valid;
  logic [CDB_PORTS*WORD_SIZE-1:0]  cdb_data;
  logic [CDB_PORTS*WORD_SIZE-1:0]  cdb_addr;
  logic [CDB_PORTS*RB_INDEX-1:0]   cdb_index;
  logic                            stall;

  modport master (
    output req, data_bus, addr_bus, RB_index_bus,
    input  grant, cdb_valid, cdb_data, cdb_addr, cdb_index, stall
  );

  modport slave (
    input  req, data_bus, addr_bus, RB_index_bus,
    output grant, cdb_valid, cdb_data, cdb_addr, cdb_index, stall
  );

endinterface

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational round-robin picker: the first CDB_PORTS set bits of i_elig,
// scanning upward from i_ptr with wrap, placed into slots in scan order.
module cdb_arbiter_rr_select
  import cdb_arbiter_pkg::*;
(
  input  logic [FU_NUM-1:0]            i_elig,
  input  fu_id_t                       i_ptr,
  output fu_id_t [CDB_PORTS-1:0]       o_sel,
  output logic   [CDB_PORTS-1:0]       o_hit,
  output fu_id_t                       o_next_ptr
);

  logic [2*FU_NUM-1:0] w_dbl;
  logic [FU_NUM-1:0]   w_rot;
  fu_id_t              w_fu [FU_NUM];

  // Rotating a doubled copy puts scan position s at bit s.
  assign w_dbl = {i_elig, i_elig} >> i_ptr;
  assign w_rot = w_dbl[FU_NUM-1:0];

  generate
    for (genvar gi = 0; gi < FU_NUM; gi++) begin : g_pos
      logic [FU_W:0] w_sum;
      assign w_sum     = {1'b0, i_ptr} + (FU_W+1)'(gi);
      assign w_fu[gi]  = (w_sum >= (FU_W+1)'(FU_NUM)) ? FU_W'(w_sum - (FU_W+1)'(FU_NUM))
                                                       : w_sum[FU_W-1:0];
    end
  endgenerate

  always_comb begin
    int cnt;
    cnt        = 0;
    o_sel      = '0;
    o_hit      = '0;
    o_next_ptr = i_ptr;
    for (int s = 0; s < FU_NUM; s++) begin
      if (w_rot[s]) begin
        for (int k = 0; k < CDB_PORTS; k++) begin
          if (cnt == k) begin
            o_sel[k]   = w_fu[s];
            o_hit[k]   = 1'b1;
            o_next_ptr = next_fu(w_fu[s]);
          end
        end
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin picks up to CDB_PORTS FU results per cycle and
// registers them onto the CDB slots at the falling clock edge.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  logic [FU_NUM-1:0]              w_elig;
  fu_id_t [CDB_PORTS-1:0]         w_sel;
  logic   [CDB_PORTS-1:0]         w_hit;
  fu_id_t                         w_next_ptr;
  cdb_slot_t                      w_slot [CDB_PORTS];
  logic [FU_NUM-1:0]              w_grant;
  logic                           w_stall;

  fu_id_t                         r_ptr;
  logic [FU_NUM-1:0]              r_grant;
  logic [CDB_PORTS-1:0]           r_valid;
  logic [CDB_PORTS*WORD_SIZE-1:0] r_data;
  logic [CDB_PORTS*WORD_SIZE-1:0] r_addr;
  logic [CDB_PORTS*RB_INDEX-1:0]  r_index;
  logic                           r_stall;

  generate
    for (genvar gi = 0; gi < FU_NUM; gi++) begin : g_elig
      assign w_elig[gi] = bus.req[gi] && (get_index(bus.RB_index_bus, gi) != NULL);
    end
  endgenerate

  cdb_arbiter_rr_select u_rr_select (
    .i_elig     (w_elig),
    .i_ptr      (r_ptr),
    .o_sel      (w_sel),
    .o_hit      (w_hit),
    .o_next_ptr (w_next_ptr)
  );

  generate
    for (genvar gi = 0; gi < CDB_PORTS; gi++) begin : g_slot
      cdb_slot_t w_s;
      logic      w_store;
      assign w_store = int'(w_sel[gi]) >= STORE_BASE;
      always_comb begin
        w_s       = '0;
        w_s.index = NULL;
        if (w_hit[gi]) begin
          w_s.valid = 1'b1;
          w_s.data  = get_data(bus.data_bus, int'(w_sel[gi]));
          w_s.index = get_index(bus.RB_index_bus, int'(w_sel[gi]));
          // Only store units drive an address; everyone else broadcasts 0.
          if (w_store) begin
            w_s.addr = get_addr(bus.addr_bus, int'(w_sel[gi]) - STORE_BASE);
          end
        end
      end
      assign w_slot[gi] = w_s;
    end
  endgenerate

  always_comb begin
    w_grant = '0;
    for (int k = 0; k < CDB_PORTS; k++) begin
      if (w_hit[k]) begin
        w_grant[w_sel[k]] = 1'b1;
      end
    end
  end

  assign w_stall = $countones(w_elig) > CDB_PORTS;

  // Flush wipes the broadcast but keeps ptr so fairness survives a squash.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_valid <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_index <= {CDB_PORTS{NULL}};
      r_stall <= 1'b0;
    end else if (flush) begin
      r_grant <= '0;
      r_valid <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_index <= {CDB_PORTS{NULL}};
      r_stall <= 1'b0;
    end else begin
      r_ptr   <= w_next_ptr;
      r_grant <= w_grant;
      r_stall <= w_stall;
      for (int k = 0; k < CDB_PORTS; k++) begin
        r_valid[k]                          <= w_slot[k].valid;
        r_data[k*WORD_SIZE +: WORD_SIZE]    <= w_slot[k].data;
        r_addr[k*WORD_SIZE +: WORD_SIZE]    <= w_slot[k].addr;
        r_index[k*RB_INDEX +: RB_INDEX]     <= w_slot[k].index;
      end
    end
  end

  assign bus.grant     = r_grant;
  assign bus.cdb_valid = r_valid;
  assign bus.cdb_data  = r_data;
  assign bus.cdb_addr  = r_addr;
  assign bus.cdb_index = r_index;
  assign bus.stall     = r_stall;

endmodule
